// File: rtl/slow_domain_merge_pkg.sv
// Shared types and constants for the slow-domain merge block: source tags,
// output buffer depth and the read-credit rule.
package slow_merge_pkg;

    typedef enum logic {
        SRC_FIFO1 = 1'b0,
        SRC_FIFO2 = 1'b1
    } src_e;

    localparam int         BUF_DEPTH    = 2;
    localparam logic [2:0] CREDIT_LIMIT = 3'd2;

    // Beats buffered plus beats still in flight, net of the one leaving this cycle.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] used;
        used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (used < CREDIT_LIMIT);
    endfunction

endpackage

// File: rtl/slow_domain_merge_if.sv
// Bundle of the two FIFO read ports, the merged output stream and the debug
// counters; master is the merge block, slave is its environment.
interface slow_domain_merge_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             empty1;
    logic [WIDTH-1:0] dout1;
    logic             rd_en1;
    logic             empty2;
    logic [WIDTH-1:0] dout2;
    logic             rd_en2;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        input  empty1, dout1, empty2, dout2, out_ready,
        output rd_en1, rd_en2, out_data, out_src, out_valid, cnt1, cnt2
    );

    modport slave (
        output empty1, dout1, empty2, dout2, out_ready,
        input  rd_en1, rd_en2, out_data, out_src, out_valid, cnt1, cnt2
    );
endinterface

// File: rtl/slow_domain_merge_out_buf.sv
// Two-entry output FIFO of {src, data}; the head sits in a register so the
// stream outputs come straight from flops and hold still under backpressure.
module merge_out_buf
    import slow_merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_src,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic             head_src,
    output logic [WIDTH-1:0] head_data
);
    localparam logic [1:0] OCC_FULL = 2'(BUF_DEPTH);

    logic [WIDTH-1:0] head_data_r, head_data_n_s;
    logic [WIDTH-1:0] tail_data_r, tail_data_n_s;
    logic             head_src_r, head_src_n_s;
    logic             tail_src_r, tail_src_n_s;
    logic [1:0]       occ_r, occ_n_s;

    // Next-state for the two slots and the occupancy.
    always_comb begin
        head_data_n_s = head_data_r;
        head_src_n_s  = head_src_r;
        tail_data_n_s = tail_data_r;
        tail_src_n_s  = tail_src_r;
        occ_n_s       = occ_r;
        case ({push, pop})
            2'b10: begin
                case (occ_r)
                    2'd0: begin
                        head_data_n_s = push_data;
                        head_src_n_s  = push_src;
                        occ_n_s       = 2'd1;
                    end
                    2'd1: begin
                        tail_data_n_s = push_data;
                        tail_src_n_s  = push_src;
                        occ_n_s       = OCC_FULL;
                    end
                    default: occ_n_s = occ_r;
                endcase
            end
            2'b01: begin
                case (occ_r)
                    OCC_FULL: begin
                        head_data_n_s = tail_data_r;
                        head_src_n_s  = tail_src_r;
                        occ_n_s       = 2'd1;
                    end
                    2'd1:    occ_n_s = 2'd0;
                    default: occ_n_s = occ_r;
                endcase
            end
            2'b11: begin
                // Simultaneous push/pop keeps occupancy; an empty buffer just accepts the push.
                case (occ_r)
                    2'd0, 2'd1: begin
                        head_data_n_s = push_data;
                        head_src_n_s  = push_src;
                        occ_n_s       = 2'd1;
                    end
                    OCC_FULL: begin
                        head_data_n_s = tail_data_r;
                        head_src_n_s  = tail_src_r;
                        tail_data_n_s = push_data;
                        tail_src_n_s  = push_src;
                    end
                    default: occ_n_s = occ_r;
                endcase
            end
            default: occ_n_s = occ_r;
        endcase
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_r <= '0;
            head_src_r  <= 1'b0;
            tail_data_r <= '0;
            tail_src_r  <= 1'b0;
            occ_r       <= 2'd0;
        end else begin
            head_data_r <= head_data_n_s;
            head_src_r  <= head_src_n_s;
            tail_data_r <= tail_data_n_s;
            tail_src_r  <= tail_src_n_s;
            occ_r       <= occ_n_s;
        end
    end

    assign occ       = occ_r;
    assign head_src  = head_src_r;
    assign head_data = head_data_r;

endmodule

// File: rtl/slow_domain_merge.sv
// Drains two async-FIFO read ports round-robin into one tagged valid/ready
// stream, with a credit limit covering the FIFOs' one-cycle read latency.
module slow_domain_merge
    import slow_merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk_slow,
    input  logic                rst,
    slow_domain_merge_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       occ_s;
    logic             head_src_s;
    logic [WIDTH-1:0] head_data_s;
    logic             valid_s;
    logic             pop_s;
    logic [WIDTH-1:0] push_data_s;
    logic             grant1_s, grant2_s, can_read_s, rd1_s, rd2_s;

    logic             inflight_r;
    src_e             inflight_src_r;
    src_e             last_grant_r;
    logic [CNT_W-1:0] cnt1_r, cnt2_r;

    assign valid_s = (occ_s != 2'd0);
    assign pop_s   = valid_s && bus.out_ready;

    // Round-robin arbitration and credit gating; reads are suppressed during reset.
    always_comb begin
        grant1_s = 1'b0;
        grant2_s = 1'b0;
        if (!bus.empty1 && !bus.empty2) begin
            if (last_grant_r == SRC_FIFO1) begin
                grant2_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (!bus.empty1) begin
            grant1_s = 1'b1;
        end else if (!bus.empty2) begin
            grant2_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
            grant2_s = 1'b0;
        end
        can_read_s = !rst && credit_ok(occ_s, inflight_r, pop_s);
        rd1_s      = grant1_s && can_read_s;
        rd2_s      = grant2_s && can_read_s;
    end

    // Track the read in flight and the last granted source.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            inflight_r     <= 1'b0;
            inflight_src_r <= SRC_FIFO1;
            last_grant_r   <= SRC_FIFO2;
        end else begin
            inflight_r     <= rd1_s || rd2_s;
            inflight_src_r <= rd2_s ? SRC_FIFO2 : SRC_FIFO1;
            if (rd1_s) begin
                last_grant_r <= SRC_FIFO1;
            end else if (rd2_s) begin
                last_grant_r <= SRC_FIFO2;
            end
        end
    end

    assign push_data_s = (inflight_src_r == SRC_FIFO2) ? bus.dout2 : bus.dout1;

    merge_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk_slow),
        .rst       (rst),
        .push      (inflight_r),
        .push_src  (inflight_src_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .occ       (occ_s),
        .head_src  (head_src_s),
        .head_data (head_data_s)
    );

    // Per-source delivered-beat counters, wrapping naturally.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            cnt1_r <= '0;
            cnt2_r <= '0;
        end else if (pop_s) begin
            if (head_src_s == SRC_FIFO2) begin
                cnt2_r <= cnt2_r + CNT_ONE;
            end else begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end
        end
    end

    assign bus.rd_en1    = rd1_s;
    assign bus.rd_en2    = rd2_s;
    assign bus.out_data  = head_data_s;
    assign bus.out_src   = head_src_s;
    assign bus.out_valid = valid_s;
    assign bus.cnt1      = cnt1_r;
    assign bus.cnt2      = cnt2_r;

endmodule

// File: tb/tb_slow_domain_merge.sv
// Directed bench for slow_domain_merge with behavioural FIFO read ports;
// counters are built 4 bits wide so the wrap is reachable.
module tb_slow_domain_merge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slow_domain_merge_if #(.WIDTH(8), .CNT_W(4)) bus ();

    slow_domain_merge #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_slow (clk),
        .rst      (rst),
        .bus      (bus)
    );

    int checks;
    int failures;
    int underflows = 0;
    int overlaps   = 0;

    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

    assign bus.empty1 = (wp1 == rp1);
    assign bus.empty2 = (wp2 == rp2);

    // FIFO read-port model: data appears the cycle after rd_en, empty follows the read.
    always @(posedge clk) begin
        if (bus.rd_en1 && bus.rd_en2) overlaps++;
        if (bus.rd_en1) begin
            if (rp1 == wp1) underflows++;
            else begin
                bus.dout1 <= mem1[rp1];
                rp1 <= rp1 + 1;
            end
        end
        if (bus.rd_en2) begin
            if (rp2 == wp2) underflows++;
            else begin
                bus.dout2 <= mem2[rp2];
                rp2 <= rp2 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1++;
    endtask

    task automatic load2(input logic [7:0] d);
        mem2[wp2] = d;
        wp2++;
    endtask

    typedef struct {
        logic       rdy;
        logic       e_rd1;
        logic       e_rd2;
        logic       e_val;
        logic [7:0] e_data;
        logic       e_src;
        logic [3:0] e_c1;
        logic [3:0] e_c2;
    } vec_t;

    vec_t tbl [9];
    logic [7:0] exp_d [8];
    logic       exp_s [8];

    initial begin
        int n, first_k, last_k, reads;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.out_ready = 1'b1;

        // Post-reset alternation with 3 beats in each FIFO.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 4'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1, 4'd1, 4'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 4'd1, 4'd1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 4'd2, 4'd1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 4'd2, 4'd2};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 1'b1, 4'd3, 4'd2};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 4'd3};

        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            load1(8'(8'h11 + i));
            load2(8'(8'h21 + i));
        end
        #1;
        chk("rst_rd_en1", 32'(bus.rd_en1), 32'd0);
        chk("rst_rd_en2", 32'(bus.rd_en2), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_src", 32'(bus.out_src), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
        chk("rst_cnt2", 32'(bus.cnt2), 32'd0);
        tick;
        chk("rst_hold_rd_en1", 32'(bus.rd_en1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("t1_rd_en1[%0d]", i), 32'(bus.rd_en1), 32'(tbl[i].e_rd1));
            chk($sformatf("t1_rd_en2[%0d]", i), 32'(bus.rd_en2), 32'(tbl[i].e_rd2));
            chk($sformatf("t1_valid[%0d]", i), 32'(bus.out_valid), 32'(tbl[i].e_val));
            chk($sformatf("t1_cnt1[%0d]", i), 32'(bus.cnt1), 32'(tbl[i].e_c1));
            chk($sformatf("t1_cnt2[%0d]", i), 32'(bus.cnt2), 32'(tbl[i].e_c2));
            if (tbl[i].e_val) begin
                chk($sformatf("t1_data[%0d]", i), 32'(bus.out_data), 32'(tbl[i].e_data));
                chk($sformatf("t1_src[%0d]", i), 32'(bus.out_src), 32'(tbl[i].e_src));
            end
            tick;
        end

        // FIFO 1 alone: A0..A3 on four consecutive cycles.
        for (int i = 0; i < 4; i++) load1(8'(8'hA0 + i));
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("t2_rd_en1[%0d]", k), 32'(bus.rd_en1), 32'(k < 4));
            chk($sformatf("t2_rd_en2[%0d]", k), 32'(bus.rd_en2), 32'd0);
            chk($sformatf("t2_valid[%0d]", k), 32'(bus.out_valid), 32'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                chk($sformatf("t2_data[%0d]", k), 32'(bus.out_data), 32'(8'hA0 + k - 2));
                chk($sformatf("t2_src[%0d]", k), 32'(bus.out_src), 32'd0);
            end
            tick;
        end
        chk("t2_cnt1", 32'(bus.cnt1), 32'd7);

        // Backpressure: both loaded, ready low for 10 cycles.
        for (int j = 0; j < 4; j++) begin
            load1(8'(8'hB0 + j));
            load2(8'(8'hC0 + j));
            exp_d[2*j]   = 8'(8'hC0 + j);
            exp_s[2*j]   = 1'b1;
            exp_d[2*j+1] = 8'(8'hB0 + j);
            exp_s[2*j+1] = 1'b0;
        end
        reads = 0;
        for (int k = 0; k < 10; k++) begin
            bus.out_ready = 1'b0;
            #1;
            if (k == 0) chk("t3_first_rd_en2", 32'(bus.rd_en2), 32'd1);
            reads += int'(bus.rd_en1) + int'(bus.rd_en2);
            if (k >= 2) begin
                chk($sformatf("t3_hold_valid[%0d]", k), 32'(bus.out_valid), 32'd1);
                chk($sformatf("t3_hold_data[%0d]", k), 32'(bus.out_data), 32'hC0);
                chk($sformatf("t3_hold_src[%0d]", k), 32'(bus.out_src), 32'd1);
            end
            tick;
        end
        chk("t3_reads_stalled", 32'(reads), 32'd2);
        n = 0;
        first_k = -1;
        last_k = -1;
        for (int k = 0; k < 20; k++) begin
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                if (n < 8) begin
                    chk($sformatf("t3_data[%0d]", n), 32'(bus.out_data), 32'(exp_d[n]));
                    chk($sformatf("t3_src[%0d]", n), 32'(bus.out_src), 32'(exp_s[n]));
                end
                if (first_k < 0) first_k = k;
                last_k = k;
                n++;
            end
            tick;
        end
        chk("t3_beats", 32'(n), 32'd8);
        chk("t3_back_to_back", 32'(last_k - first_k), 32'd7);
        chk("t3_cnt1", 32'(bus.cnt1), 32'd11);
        chk("t3_cnt2", 32'(bus.cnt2), 32'd7);

        // Single beat in FIFO 2: exactly one read and one tagged output.
        load2(8'h5A);
        reads = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k == 0) chk("t4_rd_en2", 32'(bus.rd_en2), 32'd1);
            reads += int'(bus.rd_en1) + int'(bus.rd_en2);
            if (bus.out_valid) begin
                chk("t4_data", 32'(bus.out_data), 32'h5A);
                chk("t4_src", 32'(bus.out_src), 32'd1);
                n++;
            end
            tick;
        end
        chk("t4_reads", 32'(reads), 32'd1);
        chk("t4_beats", 32'(n), 32'd1);
        chk("t4_cnt2", 32'(bus.cnt2), 32'd8);

        // Reset the cycle after rd_en1: the in-flight beat is dropped.
        load1(8'h77);
        load1(8'h78);
        #1;
        chk("t5_rd_en1", 32'(bus.rd_en1), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        chk("t5_rd_gated", 32'(bus.rd_en1), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("t5_valid_after_rst", 32'(bus.out_valid), 32'd0);
        chk("t5_cnt1", 32'(bus.cnt1), 32'd0);
        chk("t5_cnt2", 32'(bus.cnt2), 32'd0);
        chk("t5_rd_en1_again", 32'(bus.rd_en1), 32'd1);
        tick;
        chk("t5_dropped", 32'(bus.out_valid), 32'd0);
        tick;
        chk("t5_next_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_next_data", 32'(bus.out_data), 32'h78);
        tick;
        chk("t5_drained", 32'(bus.out_valid), 32'd0);

        // Counter wrap: 16 pops from FIFO 1 return cnt1 to 0.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) load1(8'(8'h30 + i));
        n = 0;
        for (int k = 0; k < 26; k++) begin
            #1;
            if (bus.out_valid) begin
                chk($sformatf("t6_data[%0d]", n), 32'(bus.out_data), 32'(8'h30 + n));
                chk($sformatf("t6_cnt1[%0d]", n), 32'(bus.cnt1), 32'(n % 16));
                n++;
            end
            tick;
        end
        chk("t6_beats", 32'(n), 32'd16);
        chk("t6_cnt1_wrap", 32'(bus.cnt1), 32'd0);
        chk("t6_cnt2", 32'(bus.cnt2), 32'd0);

        chk("no_underflow", 32'(underflows), 32'd0);
        chk("no_dual_read", 32'(overlaps), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
